manejo_escritura_resultado: RTL and testbench
=============================================

Name: manejo_escritura_resultado

Overview:
Write-side counterpart of the window-fill path. It packs filtered pixels, one byte per accepted pixel, into BITS_FILA-bit words. It writes each word to result memory through the same request/complete/release bus protocol the reader uses, and advances the address by SUMA_SIG_FILA per word. It sits between the filter datapath output and the memory arbiter.

Parameters:
BITS_FILA, 64, memory word width; must be a multiple of BITS_PIXEL.
BITS_PIXEL, 8, width of one filtered pixel.
BITS_DIRECCION_MEM, 17, memory address width.
COLUMNA_MEM, 0, first write address, loaded on reset and on each accepted iniciar_proceso.
SUMA_SIG_FILA, 256, address increment per written word.
CANTIDAD_PALABRAS, 256, number of words written per run (at least 1).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
iniciar_proceso  input  1  start a run; honoured only in REPOSO
pixel_filtrado  input  BITS_PIXEL  filtered pixel from datapath
pixel_valido  input  1  pixel_filtrado valid this cycle
transaccion_mem_completada  input  1  memory acknowledges the current write
listo_para_pixel  output  1  block accepts a pixel this cycle
escribir_mem  output  1  write request, held until acknowledged
datos_mem  output  BITS_FILA  packed word, stable while escribir_mem=1
direccion_mem  output  BITS_DIRECCION_MEM  current write address
liberar_bus_mem  output  1  one-cycle bus release pulse after each write
escritura_completa  output  1  one-cycle pulse after the last word is released

Behaviour:
- Reset (async, active-high): FSM enters REPOSO. Pixel count and word count go to 0. datos_mem=0 and direccion_mem=COLUMNA_MEM. All 1-bit outputs are 0.
- FSM states: REPOSO, ACUMULAR, ESCRIBIR, LIBERAR, FIN.
- REPOSO:
  - iniciar_proceso=1 goes to ACUMULAR next cycle.
  - It also reloads direccion_mem=COLUMNA_MEM and clears both counters.
  - pixel_valido is ignored.
- ACUMULAR:
  - listo_para_pixel=1.
  - A pixel is accepted when pixel_valido=1 in the same cycle. The packing register shifts left by BITS_PIXEL and inserts the pixel in the low byte. The first pixel therefore ends in bits [BITS_FILA-1 -: BITS_PIXEL] (most significant byte first).
  - On acceptance of pixel number BITS_FILA/BITS_PIXEL (8th by default), the count wraps to 0 and the FSM goes to ESCRIBIR.
  - iniciar_proceso is ignored outside REPOSO.
- ESCRIBIR:
  - escribir_mem=1 and listo_para_pixel=0. datos_mem and direccion_mem are held constant.
  - Latency: the 8th pixel is accepted at edge k, and escribir_mem is high in the cycle after edge k.
  - transaccion_mem_completada=1 (which may occur in the first ESCRIBIR cycle) goes to LIBERAR. escribir_mem drops in that next cycle.
  - No timeout: the block waits indefinitely.
- LIBERAR (exactly 1 cycle):
  - liberar_bus_mem=1.
  - At the end of the cycle, direccion_mem += SUMA_SIG_FILA, wrapping modulo 2^BITS_DIRECCION_MEM with no carry flag. The word count increments.
  - If the word count was CANTIDAD_PALABRAS-1, go to FIN; otherwise go to ACUMULAR.
- FIN (1 cycle): escritura_completa=1, then go to REPOSO. direccion_mem keeps its final incremented value until the next start.
- transaccion_mem_completada outside ESCRIBIR is ignored; it produces no state change.
- pixel_valido while listo_para_pixel=0 is dropped. Upstream must hold the pixel or stall; the block never buffers more than one word.
- datos_mem is the packing register itself. In ACUMULAR it shows partial contents, which are valid only while escribir_mem=1.
- Reset asserted mid-operation (including during ESCRIBIR) aborts immediately to reset values, leaving no pending request.

Test Plan:
1. Reset, then iniciar_proceso pulse, then pixels 0x11..0x88 on 8 consecutive cycles. Required: escribir_mem=1 the cycle after 0x88, datos_mem=0x1122334455667788, direccion_mem=0.
2. Hold transaccion_mem_completada=0 for 5 cycles, then 1. Required: escribir_mem and datos_mem stay stable throughout; liberar_bus_mem pulses for 1 cycle; direccion_mem=256 afterwards; listo_para_pixel returns to 1.
3. With CANTIDAD_PALABRAS=3, write 3 words with immediate ack. Required: addresses 0, 256, 512; escritura_completa pulses once after the third liberar_bus_mem; FSM returns to REPOSO and pixels are ignored.
4. With BITS_DIRECCION_MEM=9 and COLUMNA_MEM=384, write 2 words. Required: second address is (384+256) mod 512 = 128, and the third-word start address is 384.
5. Pixels gapped by pixel_valido=0 cycles, plus pixel_valido and iniciar_proceso pulses during ESCRIBIR. Required: gap cycles and ESCRIBIR-time pixels are not packed; iniciar_proceso has no effect; the word contains only accepted bytes in order.
6. Assert reset while escribir_mem=1 after 2 words. Required: all outputs return to 0 immediately and direccion_mem=COLUMNA_MEM; a new start writes the first word to COLUMNA_MEM.

Source files
------------

// File: rtl/manejo_escritura_resultado.sv
// Packs filtered pixels MSB-first into memory words and writes each word to
// result memory with the request/complete/release handshake.
module manejo_escritura_resultado #(
  parameter int unsigned BITS_FILA          = 64,
  parameter int unsigned BITS_PIXEL         = 8,
  parameter int unsigned BITS_DIRECCION_MEM = 17,
  parameter int unsigned COLUMNA_MEM        = 0,
  parameter int unsigned SUMA_SIG_FILA      = 256,
  parameter int unsigned CANTIDAD_PALABRAS  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iniciar_proceso,
  input  logic [BITS_PIXEL-1:0]         pixel_filtrado,
  input  logic                          pixel_valido,
  input  logic                          transaccion_mem_completada,
  output logic                          listo_para_pixel,
  output logic                          escribir_mem,
  output logic [BITS_FILA-1:0]          datos_mem,
  output logic [BITS_DIRECCION_MEM-1:0] direccion_mem,
  output logic                          liberar_bus_mem,
  output logic                          escritura_completa
);

  localparam int unsigned PIX_POR_FILA = BITS_FILA / BITS_PIXEL;
  localparam int unsigned BITS_CNT_PIX = (PIX_POR_FILA > 1) ? $clog2(PIX_POR_FILA) : 1;
  localparam int unsigned BITS_CNT_PAL = $clog2(CANTIDAD_PALABRAS + 1);

  localparam logic [BITS_DIRECCION_MEM-1:0] DIR_INICIAL = BITS_DIRECCION_MEM'(COLUMNA_MEM);
  localparam logic [BITS_DIRECCION_MEM-1:0] DIR_PASO    = BITS_DIRECCION_MEM'(SUMA_SIG_FILA);
  localparam logic [BITS_CNT_PIX-1:0]       ULT_PIX     = BITS_CNT_PIX'(PIX_POR_FILA - 1);
  localparam logic [BITS_CNT_PAL-1:0]       ULT_PAL     = BITS_CNT_PAL'(CANTIDAD_PALABRAS - 1);

  typedef enum logic [2:0] {
    REPOSO,
    ACUMULAR,
    ESCRIBIR,
    LIBERAR,
    FIN
  } estado_t;

  estado_t                         estado_q;
  logic [BITS_CNT_PIX-1:0]         cnt_pix_q;
  logic [BITS_CNT_PAL-1:0]         cnt_pal_q;
  logic [BITS_FILA-1:0]            datos_q;
  logic [BITS_FILA-1:0]            datos_d;
  logic [BITS_DIRECCION_MEM-1:0]   dir_q;
  logic [BITS_DIRECCION_MEM-1:0]   dir_d;
  logic                            listo_q;
  logic                            esc_q;
  logic                            lib_q;
  logic                            fin_q;

  // New pixel enters the low byte, so the first pixel of a word ends up on top.
  always_comb begin
    datos_d = (datos_q << BITS_PIXEL) | BITS_FILA'(pixel_filtrado);
    dir_d   = dir_q + DIR_PASO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cnt_pix_q <= '0;
      cnt_pal_q <= '0;
      datos_q   <= '0;
      dir_q     <= DIR_INICIAL;
      listo_q   <= 1'b0;
      esc_q     <= 1'b0;
      lib_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      lib_q <= 1'b0;
      fin_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (iniciar_proceso) begin
            estado_q  <= ACUMULAR;
            dir_q     <= DIR_INICIAL;
            cnt_pix_q <= '0;
            cnt_pal_q <= '0;
            listo_q   <= 1'b1;
          end
        end
        ACUMULAR: begin
          if (pixel_valido) begin
            datos_q <= datos_d;
            if (cnt_pix_q == ULT_PIX) begin
              cnt_pix_q <= '0;
              estado_q  <= ESCRIBIR;
              listo_q   <= 1'b0;
              esc_q     <= 1'b1;
            end else begin
              cnt_pix_q <= cnt_pix_q + 1'b1;
            end
          end
        end
        ESCRIBIR: begin
          if (transaccion_mem_completada) begin
            estado_q <= LIBERAR;
            esc_q    <= 1'b0;
            lib_q    <= 1'b1;
          end
        end
        LIBERAR: begin
          dir_q     <= dir_d;
          cnt_pal_q <= cnt_pal_q + 1'b1;
          if (cnt_pal_q == ULT_PAL) begin
            estado_q <= FIN;
            fin_q    <= 1'b1;
          end else begin
            estado_q <= ACUMULAR;
            listo_q  <= 1'b1;
          end
        end
        FIN: begin
          estado_q <= REPOSO;
        end
        default: begin
          estado_q <= REPOSO;
          listo_q  <= 1'b0;
          esc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign listo_para_pixel   = listo_q;
  assign escribir_mem       = esc_q;
  assign datos_mem          = datos_q;
  assign direccion_mem      = dir_q;
  assign liberar_bus_mem    = lib_q;
  assign escritura_completa = fin_q;

endmodule

// File: tb/tb_manejo_escritura_resultado.sv
// Scoreboard bench for manejo_escritura_resultado: a 3-word instance with
// default addressing and a 2-word instance with a 9-bit wrapping address.
module tb_manejo_escritura_resultado;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pix;
  logic        pvalid;
  logic        ack;
  logic        sel;

  logic        listo_a, esc_a, lib_a, fin_a;
  logic [63:0] datos_a;
  logic [16:0] dir_a;
  logic        listo_b, esc_b, lib_b, fin_b;
  logic [63:0] datos_b;
  logic [8:0]  dir_b;

  logic        obs_listo, obs_esc, obs_lib, obs_fin;
  logic [63:0] obs_datos;
  logic [16:0] obs_dir;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned fin_cnt = 0;
  int unsigned exp_addr;
  int unsigned mask;
  int unsigned base;

  logic [63:0] exp_data_q[$];
  int unsigned exp_addr_q[$];
  logic [63:0] held_data;
  int unsigned held_addr;
  logic        esc_prev = 1'b0;

  always #5 clk = ~clk;

  manejo_escritura_resultado #(.CANTIDAD_PALABRAS(3)) u_dut_a (
    .clk                        (clk),
    .reset                      (rst),
    .iniciar_proceso            (start & ~sel),
    .pixel_filtrado             (pix),
    .pixel_valido               (pvalid & ~sel),
    .transaccion_mem_completada (ack & ~sel),
    .listo_para_pixel           (listo_a),
    .escribir_mem               (esc_a),
    .datos_mem                  (datos_a),
    .direccion_mem              (dir_a),
    .liberar_bus_mem            (lib_a),
    .escritura_completa         (fin_a)
  );

  manejo_escritura_resultado #(
    .BITS_DIRECCION_MEM (9),
    .COLUMNA_MEM        (384),
    .CANTIDAD_PALABRAS  (2)
  ) u_dut_b (
    .clk                        (clk),
    .reset                      (rst),
    .iniciar_proceso            (start & sel),
    .pixel_filtrado             (pix),
    .pixel_valido               (pvalid & sel),
    .transaccion_mem_completada (ack & sel),
    .listo_para_pixel           (listo_b),
    .escribir_mem               (esc_b),
    .datos_mem                  (datos_b),
    .direccion_mem              (dir_b),
    .liberar_bus_mem            (lib_b),
    .escritura_completa         (fin_b)
  );

  assign obs_listo = sel ? listo_b : listo_a;
  assign obs_esc   = sel ? esc_b   : esc_a;
  assign obs_lib   = sel ? lib_b   : lib_a;
  assign obs_fin   = sel ? fin_b   : fin_a;
  assign obs_datos = sel ? datos_b : datos_a;
  assign obs_dir   = sel ? {8'd0, dir_b} : dir_a;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on the rising edge of escribir_mem, then hold-check every
  // further request cycle against the same expected word and address.
  always @(negedge clk) begin
    if (obs_fin) fin_cnt++;
    if (rst) begin
      esc_prev = 1'b0;
    end else begin
      if (obs_esc && !esc_prev) begin
        if (exp_data_q.size() == 0) begin
          check_val("sb_empty", 64'd1, 64'd0);
        end else begin
          held_data = exp_data_q.pop_front();
          held_addr = exp_addr_q.pop_front();
          check_val("sb_data", obs_datos, held_data);
          check_val("sb_addr", 64'(obs_dir), 64'(held_addr));
        end
      end else if (obs_esc) begin
        check_val("hold_data", obs_datos, held_data);
        check_val("hold_addr", 64'(obs_dir), 64'(held_addr));
      end
      esc_prev = obs_esc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_listo"}, 64'(obs_listo), 64'd0);
    check_val({tag, "_esc"},   64'(obs_esc),   64'd0);
    check_val({tag, "_lib"},   64'(obs_lib),   64'd0);
    check_val({tag, "_fin"},   64'(obs_fin),   64'd0);
    check_val({tag, "_datos"}, obs_datos,      64'd0);
    check_val({tag, "_dir"},   64'(obs_dir),   64'(base));
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = base;
    check_val("start_listo", 64'(obs_listo), 64'd1);
    check_val("start_dir", 64'(obs_dir), 64'(base));
  endtask

  task automatic send_word(input logic [63:0] w, input int unsigned gap);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'(gap); g++) begin
        pvalid = 1'b0;
        pix    = 8'hA5;
        tick();
      end
      pix    = w[63-8*i -: 8];
      pvalid = 1'b1;
      if (i == 7) begin
        exp_data_q.push_back(w);
        exp_addr_q.push_back(exp_addr);
      end
      tick();
    end
    pvalid = 1'b0;
    check_val("lat_esc", 64'(obs_esc), 64'd1);
    check_val("lat_listo", 64'(obs_listo), 64'd0);
  endtask

  task automatic ack_word(input int unsigned delay, input bit last, input bit poke);
    for (int d = 0; d < int'(delay); d++) begin
      check_val("wait_esc", 64'(obs_esc), 64'd1);
      if (poke && d == 1) begin
        pvalid = 1'b1;
        pix    = 8'hEE;
        start  = 1'b1;
      end
      tick();
      pvalid = 1'b0;
      start  = 1'b0;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("lib_pulse", 64'(obs_lib), 64'd1);
    check_val("esc_drop", 64'(obs_esc), 64'd0);
    tick();
    exp_addr = (exp_addr + 256) & mask;
    check_val("lib_end", 64'(obs_lib), 64'd0);
    check_val("dir_next", 64'(obs_dir), 64'(exp_addr));
    if (last) begin
      check_val("fin_pulse", 64'(obs_fin), 64'd1);
      check_val("fin_listo", 64'(obs_listo), 64'd0);
      tick();
      check_val("fin_end", 64'(obs_fin), 64'd0);
      check_val("fin_dir_hold", 64'(obs_dir), 64'(exp_addr));
    end else begin
      check_val("listo_back", 64'(obs_listo), 64'd1);
      check_val("no_fin", 64'(obs_fin), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pix = 8'h00; pvalid = 1'b0; ack = 1'b0; sel = 1'b0;
    mask = 32'h1FFFF; base = 0; exp_addr = 0;
    tick();
    tick();
    check_reset_outputs("rst_a");
    sel = 1'b1; base = 384;
    #1;
    check_reset_outputs("rst_b");
    sel = 1'b0; base = 0;
    rst = 1'b0;
    tick();

    // Basic packing and latency, then a delayed acknowledge.
    start_run();
    send_word(64'h1122334455667788, 0);
    check_val("t1_datos", obs_datos, 64'h1122334455667788);
    check_val("t1_dir", 64'(obs_dir), 64'd0);
    ack_word(5, 1'b0, 1'b0);

    // Gapped pixels; stray pixel and start pulses while the request is pending.
    send_word(64'hA1B2C3D4E5F60718, 2);
    ack_word(3, 1'b0, 1'b1);

    // Third word closes the run.
    send_word(64'h0102030405060708, 0);
    ack_word(0, 1'b1, 1'b0);
    check_val("fin_count_a", 64'(fin_cnt), 64'd1);
    pvalid = 1'b1;
    pix    = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("idle_listo", 64'(obs_listo), 64'd0);
      check_val("idle_esc", 64'(obs_esc), 64'd0);
    end
    pvalid = 1'b0;

    // Reset while the third request of a new run is pending.
    start_run();
    send_word(64'hDEADBEEFCAFEF00D, 0);
    ack_word(0, 1'b0, 1'b0);
    send_word(64'h0011223344556677, 1);
    ack_word(1, 1'b0, 1'b0);
    send_word(64'h8899AABBCCDDEEFF, 0);
    #5;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    start_run();
    send_word(64'hFEDCBA9876543210, 0);
    ack_word(0, 1'b0, 1'b0);

    // Wrapping 9-bit address instance starting at 384.
    sel = 1'b1; mask = 32'h1FF; base = 384;
    tick();
    start_run();
    send_word(64'h1020304050607080, 0);
    ack_word(0, 1'b0, 1'b0);
    check_val("wrap_dir", 64'(obs_dir), 64'd128);
    send_word(64'h90A0B0C0D0E0F000, 0);
    ack_word(2, 1'b1, 1'b0);
    check_val("wrap_final", 64'(obs_dir), 64'd384);
    check_val("fin_count_b", 64'(fin_cnt), 64'd2);
    start_run();
    send_word(64'h0F1E2D3C4B5A6978, 0);
    ack_word(0, 1'b0, 1'b0);

    tick();
    check_val("sb_left", 64'(exp_data_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
